// File: rtl/apb_arb_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
package apb_arb_pkg;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Bits needed to hold values 0..max_val (at least 1)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

  // Bits needed to index n requesters (at least 1)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly
// after the pointer (wrapping) wins, so the last winner has lowest priority.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = |req_i;
    cand        = 0;
    cand_idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) grant_idx_o = cand_idx;
    end
    if (any_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters. Requests are taken
// round-robin, one transfer in flight, and each completes with a one-cycle
// response pulse to its owner.
//
// Handshake: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both 1. req_ready is only raised at an arbitration point
// (IDLE, or the ACCESS cycle that completes or times out); requesters hold
// their fields stable while req_valid is 1 and must not wait on req_ready
// before raising req_valid.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_W/8-1:0]        pstrb,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr,
  output arb_state_e                 dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int CNT_W  = cnt_width(TIMEOUT_CYC);
  localparam bit TO_EN  = (TIMEOUT_CYC > 0);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [STRB_W-1:0]  pstrb_q, pstrb_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_pt;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // Last allowed ACCESS cycle without pready; pready in that cycle still wins
  assign timeout_hit = TO_EN && (state_q == ACCESS) && !pready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, grant and response logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    arb_pt      = 1'b0;

    case (state_q)
      IDLE: arb_pt = 1'b1;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready || timeout_hit) begin
          arb_pt               = 1'b1;
          state_d              = IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = (pready && !pwrite_q) ? prdata : '0;
          rsp_err_d            = pready ? pslverr : 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_pt && arb_any) begin
      req_ready = arb_grant;
      paddr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
      pwrite_d  = req_write[arb_idx];
      pwdata_d  = req_wdata[arb_idx*DATA_W +: DATA_W];
      pstrb_d   = req_write[arb_idx] ? req_strb[arb_idx*STRB_W +: STRB_W] : '0;
      ptr_d     = arb_idx;
      owner_d   = arb_idx;
      state_d   = SETUP;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State, APB and response registers with synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pstrb       = pstrb_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: table of single transfers, random transfers,
// and hand-written back-to-back, timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int EXP_W       = 1 + 1 + DATA_W;
  localparam int APB_W       = ADDR_W + 1 + DATA_W + STRB_W;

  // ---------------- clock / reset / DUT ----------------
  logic                       pclk    = 1'b0;
  logic                       presetn = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr  = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata = '0;
  logic [NUM_REQ*STRB_W-1:0]  req_strb  = '0;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic [ADDR_W-1:0]          paddr;
  logic                       psel, penable, pwrite;
  logic [STRB_W-1:0]          pstrb;
  logic [DATA_W-1:0]          pwdata;
  logic [DATA_W-1:0]          prdata  = '0;
  logic                       pready  = 1'b0;
  logic                       pslverr = 1'b0;
  arb_state_e                 dbg_state;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [APB_W-1:0] exp_apb_q[$];
  int grant_q[$];
  int acc_run = 0, last_acc = 0;
  int psel_run = 0, max_psel_run = 0;

  // Slave behaviour knobs
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic        slv_stuck = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_n     = 0;

  typedef struct {
    int          idx;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          waits;
    logic        serr;
    logic        stuck;
    logic [31:0] prd;
    logic [31:0] exp_rd;
    logic        exp_er;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  always @(negedge pclk) begin
    prdata = slv_rdata;
    if (psel && penable) begin
      pready  = !slv_stuck && (slv_n >= slv_wait);
      pslverr = slv_err;
      slv_n++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      slv_n   = 0;
    end
  end

  // ---------------- monitor: SETUP beats and responses ----------------
  always @(negedge pclk) begin
    logic [APB_W-1:0] ea;
    logic [EXP_W-1:0] er;
    logic [1:0]       exp_vld;
    if (psel && penable) acc_run++;
    else if (acc_run != 0) begin
      last_acc = acc_run;
      acc_run  = 0;
    end
    if (psel) begin
      psel_run++;
      if (psel_run > max_psel_run) max_psel_run = psel_run;
    end else psel_run = 0;

    if (presetn && psel && !penable) begin
      if (exp_apb_q.size() == 0) check("setup_unexpected", 64'd1, 64'd0);
      else begin
        ea = exp_apb_q.pop_front();
        check("setup_beat", {paddr, pwrite, pwdata, pstrb}, ea);
      end
    end

    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 64'd0);
      else begin
        er      = exp_q.pop_front();
        exp_vld = er[EXP_W-1] ? 2'b10 : 2'b01;
        check("rsp_valid", rsp_valid, exp_vld);
        check("rsp_err", rsp_err, er[DATA_W]);
        check("rsp_rdata", rsp_rdata, er[DATA_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int idx, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input logic exp_er);
    logic got;
    int   n;
    logic o;
    n = 0;
    o = (idx != 0);
    @(negedge pclk);
    req_write[idx]                = wr;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wd;
    req_strb[idx*STRB_W +: STRB_W] = st;
    req_valid[idx]                = 1'b1;
    forever begin
      #1 got = req_ready[idx];
      @(posedge pclk);
      if (got) begin
        exp_apb_q.push_back({addr, wr, wd, wr ? st : 4'h0});
        exp_q.push_back({o, exp_er, exp_rd});
        grant_q.push_back(idx);
        break;
      end
      n++;
      if (n > 300) begin
        check("issue_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge pclk);
    end
    @(negedge pclk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || exp_apb_q.size() != 0) begin
      @(negedge pclk);
      #2;
      n++;
      if (n > 200) begin
        check("rsp_wait_timeout", exp_q.size(), 64'd0);
        exp_q.delete();
        exp_apb_q.delete();
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    slv_wait  = v.waits;
    slv_err   = v.serr;
    slv_stuck = v.stuck;
    slv_rdata = v.prd;
    issue(v.idx, v.wr, v.addr, v.wd, v.st, v.exp_rd, v.exp_er);
    wait_idle();
    check({tag, "_access_len"}, last_acc, v.exp_acc);
    check({tag, "_bus_idle"}, {psel, penable}, 64'd0);
    slv_stuck = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    int   w;
    //          idx wr  addr     wdata         st    wt serr stk prdata        exp_rd        er  acc
    vecs[0] = '{0, 1, 12'h004, 32'hA5A5_1234, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 32'h0,         0, 1};
    vecs[1] = '{1, 0, 12'h008, 32'h1111_1111, 4'hF, 3, 0, 0, 32'h0000_00C3, 32'h0000_00C3, 0, 4};
    vecs[2] = '{0, 1, 12'hFFC, 32'h0BAD_F00D, 4'h3, 0, 1, 0, 32'hDEAD_0001, 32'h0,         1, 1};
    vecs[3] = '{1, 0, 12'h010, 32'h2222_2222, 4'hF, 1, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 2};
    vecs[4] = '{0, 0, 12'h020, 32'h3333_3333, 4'hF, 0, 0, 1, 32'h7777_7777, 32'h0,         1, 16};
    vecs[5] = '{1, 1, 12'h024, 32'hCAFE_0005, 4'h5, 2, 1, 0, 32'h4444_4444, 32'h0,         1, 3};
    vecs[6] = '{0, 0, 12'h028, 32'h5555_5555, 4'hF, 0, 1, 0, 32'h0000_ABCD, 32'h0000_ABCD, 1, 1};

    // Reset state
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_state", dbg_state, IDLE);
    check("rst_apb", {paddr, psel, penable, pwrite, pstrb, pwdata}, 64'd0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("rst_ready", req_ready, 64'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // Back-to-back: both requesters continuously valid, four transfers
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h5A5A_0001;
    grant_q.delete();
    max_psel_run = 0;
    fork
      begin
        issue(0, 1'b1, 12'h100, 32'h0000_0A00, 4'hF, 32'h0, 1'b0);
        issue(0, 1'b1, 12'h104, 32'h0000_0A01, 4'h1, 32'h0, 1'b0);
      end
      begin
        issue(1, 1'b0, 12'h200, 32'h0, 4'hF, 32'h5A5A_0001, 1'b0);
        issue(1, 1'b1, 12'h204, 32'h0000_0B01, 4'h8, 32'h0, 1'b0);
      end
    join
    wait_idle();
    check("b2b_grants", grant_q.size(), 64'd4);
    if (grant_q.size() == 4) begin
      check("b2b_g0", grant_q[0], 64'd0);
      check("b2b_g1", grant_q[1], 64'd1);
      check("b2b_g2", grant_q[2], 64'd0);
      check("b2b_g3", grant_q[3], 64'd1);
    end
    check("b2b_psel_run", max_psel_run, 64'd8);

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Random single transfers
    for (int k = 0; k < 6; k++) begin
      w        = $urandom_range(0, 3);
      rv.idx   = $urandom_range(0, 1);
      rv.wr    = 1'($urandom_range(0, 1));
      rv.addr  = 12'($urandom_range(0, 1023) * 4);
      rv.wd    = $urandom;
      rv.st    = 4'($urandom_range(1, 15));
      rv.waits = w;
      rv.serr  = 1'($urandom_range(0, 1));
      rv.stuck = 1'b0;
      rv.prd   = $urandom;
      rv.exp_rd  = rv.wr ? 32'h0 : rv.prd;
      rv.exp_er  = rv.serr;
      rv.exp_acc = w + 1;
      run_vec(rv, $sformatf("rnd%0d", k));
    end

    // Reset during ACCESS: transfer discarded, pointer back to requester 0
    slv_stuck = 1'b1; slv_err = 1'b0;
    issue(0, 1'b0, 12'h030, 32'h0, 4'hF, 32'h0, 1'b0);
    w = 0;
    while (!(psel && penable) && w < 20) begin
      @(negedge pclk);
      w++;
    end
    check("mid_rst_in_access", {psel, penable}, 64'd3);
    exp_q.delete();
    exp_apb_q.delete();
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    check("mid_rst_bus_drop", {psel, penable}, 64'd0);
    check("mid_rst_no_rsp", rsp_valid, 64'd0);
    @(negedge pclk);
    check("mid_rst_state", dbg_state, IDLE);
    presetn   = 1'b1;
    slv_stuck = 1'b0;
    repeat (4) @(negedge pclk);
    check("mid_rst_quiet", {rsp_valid, psel}, 64'd0);
    grant_q.delete();
    slv_rdata = 32'h0000_0099;
    fork
      issue(0, 1'b0, 12'h040, 32'h0, 4'hF, 32'h0000_0099, 1'b0);
      issue(1, 1'b1, 12'h044, 32'hFACE_0001, 4'hF, 32'h0, 1'b0);
    join
    wait_idle();
    check("post_rst_grants", grant_q.size(), 64'd2);
    if (grant_q.size() == 2) begin
      check("post_rst_first", grant_q[0], 64'd0);
      check("post_rst_second", grant_q[1], 64'd1);
    end

    repeat (3) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
